pixel_compositor: RTL and testbench
===================================

// Module: pixel_compositor
// PURPOSE
//  Final video stage between the sprite renderers and the VGA output pins.
//  - Merges NUM_LAYERS sprite pixel streams by fixed priority over a background colour.
//  - Delays hsync/vsync/blank so they line up with the sprite pipeline.
//  - Applies a frame-counted full-screen "strike flash" tint.
//  Renderers output 24'h000000 outside their box; 24'h000000 is the transparency key.
// PARAMETERS
//  NUM_LAYERS   4          number of sprite layer inputs; layer 0 = highest priority
//  PIPE_DELAY   3          cycles a renderer's pixel lags hcount/vcount; must be >= 1
//  FLASH_FRAMES 30         frames the flash tint stays active after a trigger
//  FLASH_COLOR  24'hFF0000 colour that replaces background pixels while flashing
// PORTS
//  pixel_clk     in   1             pixel clock; all logic on rising edge
//  reset         in   1             synchronous, active-high
//  hsync_in      in   1             from timing generator, active-low, aligned with hcount
//  vsync_in      in   1             from timing generator, active-low, aligned with vcount
//  blank_in      in   1             from timing generator, 1 = outside visible area
//  layer_pixels  in   24*NUM_LAYERS layer i occupies bits [24*i+23 : 24*i], {R,G,B}
//  bg_color      in   24            requested background colour
//  flash_trigger in   1             single-cycle pulse: start or restart the flash
//  hsync_out     out  1             hsync_in delayed by PIPE_DELAY+1
//  vsync_out     out  1             vsync_in delayed by PIPE_DELAY+1
//  blank_out     out  1             blank_in delayed by PIPE_DELAY+1
//  pixel_out     out  24            composited pixel, aligned with the *_out syncs
//  flash_active  out  1             1 while flash counter != 0
// BEHAVIOUR
//  Reset values
//  - pixel_out = 0; hsync_out = vsync_out = 1; blank_out = 1; flash_active = 0.
//  - Every delay stage: sync = 1, blank = 1.
//  - bg_reg = 0; flash_cnt = 0.
//  Sync delay
//  - hsync/vsync/blank each pass through a PIPE_DELAY-stage shift register.
//  - One further output register gives total latency PIPE_DELAY+1.
//  Compositing (one registered stage, 1-cycle latency from layer_pixels to pixel_out)
//  - Candidate pixel = lowest-index layer whose value != 0.
//  - If no layer is non-zero: use bg_reg, or FLASH_COLOR when flash_cnt != 0.
//  - pixel_out = 0 whenever the delayed blank (stage PIPE_DELAY) = 1.
//  - Flash never overrides a non-zero sprite pixel.
//  Frame boundary
//  - Defined as the cycle where the stage-PIPE_DELAY vsync goes 1 -> 0.
//  - bg_reg <= bg_color only on the frame-boundary cycle. Changes to bg_color
//    mid-frame take effect from the next frame (no tearing).
//  Flash counter (width = $clog2(FLASH_FRAMES+1))
//  - flash_trigger = 1: flash_cnt <= FLASH_FRAMES. Reload also applies when the
//    counter is already nonzero.
//  - Else, on a frame boundary with flash_cnt != 0: flash_cnt <= flash_cnt - 1.
//  - Counter saturates at 0; it never wraps.
//  - Trigger and frame boundary in the same cycle: reload wins, no decrement.
//  - flash_active = (flash_cnt != 0), registered.
//  Reset mid-frame
//  - All state returns to reset values; a flash in progress is cancelled.
//  - Outputs show blank / inactive syncs until real syncs propagate, PIPE_DELAY+1 cycles.
// STRUCTURE
//  Package kt_video_pkg
//  - PIXEL_W = 24, COLOR_BLACK = 24'h000000, SYNC_INACTIVE = 1'b1.
//  - Shared by renderers and this block.
//  Sub-module sync_delay_line #(WIDTH, DEPTH, RESET_VAL)
//  - Generic resettable shift register.
//  - Instantiated once here, 3 bits wide, DEPTH = PIPE_DELAY, RESET_VAL = 3'b111.
//  - Compositor mux and flash counter stay in this module.
// TESTING
//  1. Reset: hold reset 2 cycles with arbitrary inputs ->
//     pixel_out = 0, hsync_out = vsync_out = blank_out = 1, flash_active = 0.
//  2. Latency: one-cycle low pulse on hsync_in ->
//     hsync_out low exactly PIPE_DELAY+1 = 4 cycles later, for 1 cycle.
//  3. Priority: layer0 = 0, layer1 = 24'h00FF00, layer2 = 24'h0000FF, blank low ->
//     pixel_out = 24'h00FF00 next cycle. All layers 0 -> bg_reg.
//     Delayed blank high -> pixel_out = 0.
//  4. Background latch: change bg_color to 24'h123456 mid-frame ->
//     pixel_out keeps the old bg until the next vsync falling edge, then 24'h123456.
//  5. Flash: pulse flash_trigger ->
//     background pixels = 24'hFF0000 and flash_active = 1 for exactly 30 frame
//     boundaries; sprite pixels unchanged. Retrigger at frame 10 -> 30 more frames.
//  6. Collision: flash_trigger coincident with a frame boundary ->
//     flash_cnt = FLASH_FRAMES afterwards, not FLASH_FRAMES-1.

Source files
------------

// File: rtl/kt_video_pkg.sv
// Shared video definitions used by the sprite renderers and the output compositor.
package kt_video_pkg;
   localparam int unsigned PIXEL_W = 24;
   localparam logic [PIXEL_W-1:0] COLOR_BLACK = 24'h000000;
   localparam logic SYNC_INACTIVE = 1'b1;
endpackage

// File: rtl/sync_delay_line.sv
// Generic resettable shift register; dout is din delayed by DEPTH cycles.
module sync_delay_line #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] stages [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) stages[i] <= RESET_VAL;
      end else begin
         stages[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) stages[i] <= stages[i-1];
      end
   end

   assign dout = stages[DEPTH-1];
endmodule

// File: rtl/pixel_compositor.sv
// Final video stage: priority-merges sprite layers over a per-frame background, aligns
// syncs with the sprite pipeline and applies a frame-counted full-screen flash tint.
module pixel_compositor
   import kt_video_pkg::*;
#(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned PIPE_DELAY = 3,
   parameter int unsigned FLASH_FRAMES = 30,
   parameter logic [PIXEL_W-1:0] FLASH_COLOR = 24'hFF0000
) (
   input  logic                          pixel_clk,
   input  logic                          reset,
   input  logic                          hsync_in,
   input  logic                          vsync_in,
   input  logic                          blank_in,
   input  logic [PIXEL_W*NUM_LAYERS-1:0] layer_pixels,
   input  logic [PIXEL_W-1:0]            bg_color,
   input  logic                          flash_trigger,
   output logic                          hsync_out,
   output logic                          vsync_out,
   output logic                          blank_out,
   output logic [PIXEL_W-1:0]            pixel_out,
   output logic                          flash_active
);
   localparam int unsigned CNT_W = $clog2(FLASH_FRAMES + 1);

   logic              dly_hsync, dly_vsync, dly_blank;
   logic              frame_start;
   logic              hit;
   logic [PIXEL_W-1:0] cand;
   logic [PIXEL_W-1:0] pixel_d;
   logic [PIXEL_W-1:0] bg_reg;
   logic [CNT_W-1:0]   flash_cnt, flash_cnt_d;

   sync_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL ({SYNC_INACTIVE, SYNC_INACTIVE, 1'b1})
   ) u_sync_delay (
      .clk   (pixel_clk),
      .reset (reset),
      .din   ({hsync_in, vsync_in, blank_in}),
      .dout  ({dly_hsync, dly_vsync, dly_blank})
   );

   // vsync_out holds the previous delayed vsync, so this is its falling edge.
   assign frame_start = vsync_out & ~dly_vsync;

   // Scan from the lowest priority up so the lowest-index opaque layer wins.
   always_comb begin
      hit  = 1'b0;
      cand = COLOR_BLACK;
      for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
         if (layer_pixels[PIXEL_W*i +: PIXEL_W] != COLOR_BLACK) begin
            hit  = 1'b1;
            cand = layer_pixels[PIXEL_W*i +: PIXEL_W];
         end
      end
   end

   always_comb begin
      pixel_d = bg_reg;
      if (dly_blank) begin
         pixel_d = COLOR_BLACK;
      end else if (hit) begin
         pixel_d = cand;
      end else if (flash_cnt != '0) begin
         pixel_d = FLASH_COLOR;
      end
   end

   // Reload takes precedence over a coincident frame-boundary decrement.
   always_comb begin
      flash_cnt_d = flash_cnt;
      if (flash_trigger) begin
         flash_cnt_d = CNT_W'(FLASH_FRAMES);
      end else if (frame_start && flash_cnt != '0) begin
         flash_cnt_d = flash_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         hsync_out    <= SYNC_INACTIVE;
         vsync_out    <= SYNC_INACTIVE;
         blank_out    <= 1'b1;
         pixel_out    <= COLOR_BLACK;
         flash_active <= 1'b0;
         bg_reg       <= COLOR_BLACK;
         flash_cnt    <= '0;
      end else begin
         hsync_out    <= dly_hsync;
         vsync_out    <= dly_vsync;
         blank_out    <= dly_blank;
         pixel_out    <= pixel_d;
         flash_active <= (flash_cnt_d != '0);
         flash_cnt    <= flash_cnt_d;
         if (frame_start) bg_reg <= bg_color;
      end
   end
endmodule

// File: tb/tb_pixel_compositor.sv
// Directed, table-driven bench for pixel_compositor with default parameters.
module tb_pixel_compositor;
   logic        pixel_clk = 1'b0;
   logic        reset;
   logic        hsync_in, vsync_in, blank_in;
   logic [95:0] layer_pixels;
   logic [23:0] bg_color;
   logic        flash_trigger;
   logic        hsync_out, vsync_out, blank_out;
   logic [23:0] pixel_out;
   logic        flash_active;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [95:0] layers;
      logic [23:0] expect_px;
   } vec_t;
   vec_t vecs [6];

   pixel_compositor dut (
      .pixel_clk     (pixel_clk),
      .reset         (reset),
      .hsync_in      (hsync_in),
      .vsync_in      (vsync_in),
      .blank_in      (blank_in),
      .layer_pixels  (layer_pixels),
      .bg_color      (bg_color),
      .flash_trigger (flash_trigger),
      .hsync_out     (hsync_out),
      .vsync_out     (vsync_out),
      .blank_out     (blank_out),
      .pixel_out     (pixel_out),
      .flash_active  (flash_active)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic step();
      @(posedge pixel_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One-cycle vsync pulse, then enough idle cycles for the pipeline to drain.
   task automatic frame();
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      repeat (5) step();
   endtask

   initial begin
      reset = 1'b1;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      blank_in = 1'b0;
      layer_pixels = {24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
      bg_color = 24'h555555;
      flash_trigger = 1'b0;

      // Reset with arbitrary inputs
      repeat (2) step();
      chk("reset pixel_out", pixel_out, 24'h0);
      chk("reset hsync_out", 24'(hsync_out), 24'h1);
      chk("reset vsync_out", 24'(vsync_out), 24'h1);
      chk("reset blank_out", 24'(blank_out), 24'h1);
      chk("reset flash_active", 24'(flash_active), 24'h0);

      hsync_in = 1'b1;
      vsync_in = 1'b1;
      blank_in = 1'b1;
      layer_pixels = '0;
      reset = 1'b0;
      repeat (5) step();

      // hsync latency = 4
      hsync_in = 1'b0;
      step();
      hsync_in = 1'b1;
      repeat (2) step();
      chk("hsync latency 3", 24'(hsync_out), 24'h1);
      step();
      chk("hsync latency 4", 24'(hsync_out), 24'h0);
      step();
      chk("hsync latency 5", 24'(hsync_out), 24'h1);

      // Latch a background, open the visible area
      bg_color = 24'hABCDEF;
      frame();
      blank_in = 1'b0;
      repeat (5) step();
      chk("blank_out low", 24'(blank_out), 24'h0);

      vecs[0] = '{96'h0, 24'hABCDEF};
      vecs[1] = '{{24'h0, 24'h0000FF, 24'h00FF00, 24'h0}, 24'h00FF00};
      vecs[2] = '{{24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'h112233}, 24'h112233};
      vecs[3] = '{{24'h000001, 24'h0, 24'h0, 24'h0}, 24'h000001};
      vecs[4] = '{{24'hFFFFFF, 24'h0000FF, 24'h0, 24'h0}, 24'h0000FF};
      vecs[5] = '{96'h0, 24'hABCDEF};
      for (int i = 0; i < 6; i++) begin
         layer_pixels = vecs[i].layers;
         step();
         chk($sformatf("priority vec %0d", i), pixel_out, vecs[i].expect_px);
      end

      // Delayed blank forces black even over a sprite
      layer_pixels = {24'h0, 24'h0, 24'h0, 24'h777777};
      blank_in = 1'b1;
      repeat (3) step();
      chk("blank pre-delay", pixel_out, 24'h777777);
      step();
      chk("blank forces 0", pixel_out, 24'h0);
      chk("blank_out high", 24'(blank_out), 24'h1);
      blank_in = 1'b0;
      layer_pixels = '0;
      repeat (5) step();

      // Background change mid-frame only lands after the next vsync edge
      bg_color = 24'h123456;
      repeat (3) step();
      chk("bg hold mid-frame", pixel_out, 24'hABCDEF);
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      repeat (3) step();
      chk("bg hold at boundary", pixel_out, 24'hABCDEF);
      chk("vsync_out low", 24'(vsync_out), 24'h0);
      step();
      chk("bg new frame", pixel_out, 24'h123456);
      repeat (3) step();

      // Flash with retrigger at frame 10
      flash_trigger = 1'b1;
      step();
      flash_trigger = 1'b0;
      chk("flash active on trigger", 24'(flash_active), 24'h1);
      step();
      chk("flash bg tint", pixel_out, 24'hFF0000);
      layer_pixels = {24'h0, 24'h0, 24'h00FF00, 24'h0};
      step();
      chk("flash keeps sprite", pixel_out, 24'h00FF00);
      layer_pixels = '0;
      for (int f = 1; f <= 10; f++) begin
         frame();
         chk($sformatf("flash frame %0d", f), 24'(flash_active), 24'h1);
      end
      flash_trigger = 1'b1;
      step();
      flash_trigger = 1'b0;
      for (int f = 1; f <= 30; f++) begin
         frame();
         chk($sformatf("retrigger frame %0d", f), 24'(flash_active), (f < 30) ? 24'h1 : 24'h0);
         if (f == 29) chk("tint frame 29", pixel_out, 24'hFF0000);
      end
      chk("tint gone", pixel_out, 24'h123456);
      frame();
      chk("flash saturates", 24'(flash_active), 24'h0);

      // Trigger coincident with a frame boundary: reload wins
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      repeat (2) step();
      flash_trigger = 1'b1;
      step();
      flash_trigger = 1'b0;
      repeat (3) step();
      for (int f = 1; f <= 30; f++) begin
         frame();
         chk($sformatf("collision frame %0d", f), 24'(flash_active), (f < 30) ? 24'h1 : 24'h0);
      end

      // Reset mid-flash
      flash_trigger = 1'b1;
      step();
      flash_trigger = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midreset flash", 24'(flash_active), 24'h0);
      chk("midreset pixel", pixel_out, 24'h0);
      chk("midreset blank", 24'(blank_out), 24'h1);
      chk("midreset vsync", 24'(vsync_out), 24'h1);
      repeat (3) step();
      chk("post-reset blank 3", 24'(blank_out), 24'h1);
      step();
      chk("post-reset blank 4", 24'(blank_out), 24'h0);
      step();
      chk("post-reset bg cleared", pixel_out, 24'h0);
      chk("post-reset flash", 24'(flash_active), 24'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
